systolic_array_loader: RTL and testbench
========================================

Name: systolic_array_loader

Overview:
- Memory-side sequencer that streams operand rows into the systolic array control unit.
- Drives the control unit's inputs: weight_en, input_en, partial_en, row_en, plus the shared row data bus. Respects fifo_has_space backpressure.
- One command loads array_dim weight rows, then num_inputs (input row, partial row) pairs fetched from a scratchpad read port.
- Sits between the scratchpad and the array's control unit/FIFOs.

Parameters:
- array_dim, 4, systolic array rows/cols
- data_w, 16, element width (FP16)
- addr_w, 16, scratchpad row-address width

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, synchronous, active-low
- start  in  1  command pulse; sampled only in IDLE
- base_w_addr  in  addr_w  first weight row address
- base_i_addr  in  addr_w  first input row address
- base_p_addr  in  addr_w  first partial row address
- num_inputs  in  16  input/partial row pairs to send (0 = weights only)
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- rd_req  out  1  scratchpad read request
- rd_addr  out  addr_w  scratchpad row address
- rd_valid  in  1  read data valid (completes rd_req)
- rd_data  in  array_dim*data_w  row read data
- fifo_has_space  in  1  array FIFOs can accept one input+partial pair
- weight_en  out  1  bus carries a weight row
- input_en  out  1  bus carries an input row
- partial_en  out  1  bus carries a partial-sum row
- row_en  out  $clog2(array_dim)  target row index
- row_data  out  array_dim*data_w  row payload

Behaviour:
- Reset (nRST low at a CLK edge): state IDLE, counters cleared. All outputs 0: busy, done, rd_req, rd_addr, weight_en, input_en, partial_en, row_en, row_data. Reset mid-command abandons the command; no done pulse is issued.
- States: IDLE, W_RD, I_WAIT, I_RD, P_RD, DONE.
- IDLE: on start, latch the three base addresses and num_inputs, clear w_cnt and k, set busy=1, go to W_RD.
- W_RD:
  - rd_req=1 with rd_addr=base_w+w_cnt, held until rd_valid. rd_valid in the same cycle as rd_req completes the read.
  - On rd_valid, in the next cycle (registered): weight_en=1, row_en=w_cnt, row_data=rd_data, for exactly one cycle. w_cnt then increments.
  - After row array_dim-1: go to I_WAIT, or to DONE if num_inputs==0.
- I_WAIT: rd_req=0. Stay until fifo_has_space=1, then go to I_RD (no extra idle cycle).
- I_RD: read base_i+k. Next cycle after rd_valid: input_en=1, row_en=k[$clog2(array_dim)-1:0] (wraps modulo array_dim), row_data=rd_data. Go to P_RD.
- P_RD:
  - Read base_p+k. Next cycle after rd_valid: partial_en=1, same row_en as the preceding input.
  - Then k++. If k==num_inputs go to DONE, else go to I_WAIT.
  - fifo_has_space is not rechecked between an input and its partial; space is reserved per pair.
- DONE: done=1 for one cycle, busy=0 from the next cycle, return to IDLE.
- Bus exclusivity:
  - At most one of weight_en/input_en/partial_en is high in any cycle.
  - When all three are low, row_en and row_data hold their last values.
- Latency: with zero-wait memory (rd_valid same cycle as rd_req), each row takes 2 cycles. The first weight_en appears 2 cycles after start.
- Command and address handling:
  - start while busy is ignored; latched parameters are unaffected.
  - Address arithmetic is modulo 2^addr_w, wrapping silently.
  - rd_valid while rd_req=0 is ignored.
  - fifo_has_space toggling during W_RD/P_RD is ignored.

Decomposition:
- Shared package systolic_pkg: loader_state_t enum; ROW_W = array_dim*data_w; ROW_IDX_W = $clog2(array_dim).
- One sub-module, loader_rd_port: holds rd_req/rd_addr until rd_valid, then registers the captured row and asserts a one-cycle captured pulse.
- The FSM sets the row type and row index and sequences the reads.

Test Plan:
- Weights only: num_inputs=0, base_w=0x10, zero-wait memory returning row index as data -> weight_en on 4 consecutive odd cycles with row_en 0,1,2,3 and addrs 0x10–0x13; done 1 cycle after the last weight row; input_en/partial_en never high.
- Full command: num_inputs=6, base_i=0x40, base_p=0x80 -> 4 weight rows, then input/partial pairs alternating. row_en goes 0,1,2,3,0,1 (wrap); addrs 0x40–0x45 and 0x80–0x85; done after the 6th partial.
- Backpressure: fifo_has_space=0 for 5 cycles after the weights -> rd_req stays low in I_WAIT; the input read issues the cycle space rises. Dropping space between input and partial does not stall the partial.
- Memory wait states: rd_valid delayed 3 cycles per read -> rd_req/rd_addr stay stable throughout; each en pulse is exactly 1 cycle; no duplicate rows.
- Start while busy: a second start mid-command with different bases -> ignored; the original address sequence completes unchanged.
- Reset mid-operation: nRST low during the 2nd input pair -> all outputs 0 the next cycle, no done pulse. A new start afterwards runs cleanly from weight row 0.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and default sizing for the systolic array loader.
//
// Contents:
//   ARRAY_DIM / DATA_W / ADDR_W  default array size, element width, scratchpad address width
//   ROW_W                        width of one full array row (ARRAY_DIM * DATA_W)
//   ROW_IDX_W                    width of a row index ($clog2(ARRAY_DIM))
//   loader_state_t               sequencer FSM states
//   row_kind_t                   which operand type a captured row carries
package systolic_pkg;

   localparam int unsigned ARRAY_DIM = 4;
   localparam int unsigned DATA_W    = 16;
   localparam int unsigned ADDR_W    = 16;
   localparam int unsigned ROW_W     = ARRAY_DIM * DATA_W;
   localparam int unsigned ROW_IDX_W = $clog2(ARRAY_DIM);

   typedef enum logic [2:0] {
      StIdle,
      StWRd,
      StIWait,
      StIRd,
      StPRd,
      StDone
   } loader_state_t;

   typedef enum logic [1:0] {
      RowWeight,
      RowInput,
      RowPartial
   } row_kind_t;

endpackage

// File: rtl/loader_rd_port.sv
// Scratchpad read port for the systolic array loader.
//
// Presents a read request while the sequencer asks for one, holds request and address
// steady until the memory answers, then registers the returned row together with a caller
// supplied tag (row type + row index) and raises a one-cycle captured pulse.
//
// Ports:
//   CLK, nRST      clock, synchronous active-low reset
//   req            sequencer wants a read of addr this cycle
//   addr           row address for the read
//   tag            metadata stored alongside the captured row
//   rd_req/rd_addr scratchpad read request and address
//   rd_valid       read completes in a cycle where rd_req is high
//   rd_data        row returned by the scratchpad
//   captured       one-cycle pulse, the cycle after a read completes
//   cap_data       last captured row (held)
//   cap_tag        tag of the last captured row (held)
module loader_rd_port #(
   parameter int unsigned addr_w = 16,
   parameter int unsigned row_w  = 64,
   parameter int unsigned tag_w  = 4
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              req,
   input  logic [addr_w-1:0] addr,
   input  logic [tag_w-1:0]  tag,
   output logic              rd_req,
   output logic [addr_w-1:0] rd_addr,
   input  logic              rd_valid,
   input  logic [row_w-1:0]  rd_data,
   output logic              captured,
   output logic [row_w-1:0]  cap_data,
   output logic [tag_w-1:0]  cap_tag
);

   logic             cap_q;
   logic [row_w-1:0] data_q;
   logic [tag_w-1:0] tag_q;
   logic             fire;

   // No new request during the capture cycle: the sequencer only advances on the pulse,
   // so this keeps one read per row and gives the two-cycle row cadence.
   assign rd_req  = req & ~cap_q;
   assign rd_addr = rd_req ? addr : '0;
   assign fire    = rd_req & rd_valid;

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         cap_q  <= 1'b0;
         data_q <= '0;
         tag_q  <= '0;
      end else begin
         cap_q <= fire;
         if (fire) begin
            data_q <= rd_data;
            tag_q  <= tag;
         end
      end
   end

   assign captured = cap_q;
   assign cap_data = data_q;
   assign cap_tag  = tag_q;

endmodule

// File: rtl/systolic_array_loader.sv
// Memory-side sequencer feeding the systolic array control unit.
//
// One command loads array_dim weight rows, then num_inputs (input row, partial row) pairs
// read from the scratchpad. Each input/partial pair is only started when the array FIFOs
// report space for a whole pair.
//
// Ports:
//   CLK, nRST                 clock, synchronous active-low reset
//   start                     command pulse, honoured only when idle
//   base_w/i/p_addr           first weight / input / partial row address
//   num_inputs                number of input/partial pairs (0 = weights only)
//   busy, done                command in progress, one-cycle completion pulse
//   rd_req, rd_addr           scratchpad read request / row address
//   rd_valid, rd_data         scratchpad read completion / row data
//   fifo_has_space            array FIFOs can accept one input+partial pair
//   weight_en/input_en/partial_en  row type strobes (at most one high)
//   row_en, row_data          target row index and payload (held when no strobe)
module systolic_array_loader
   import systolic_pkg::*;
#(
   parameter int unsigned array_dim = ARRAY_DIM,
   parameter int unsigned data_w    = DATA_W,
   parameter int unsigned addr_w    = ADDR_W
) (
   input  logic                          CLK,
   input  logic                          nRST,
   input  logic                          start,
   input  logic [addr_w-1:0]             base_w_addr,
   input  logic [addr_w-1:0]             base_i_addr,
   input  logic [addr_w-1:0]             base_p_addr,
   input  logic [15:0]                   num_inputs,
   output logic                          busy,
   output logic                          done,
   output logic                          rd_req,
   output logic [addr_w-1:0]             rd_addr,
   input  logic                          rd_valid,
   input  logic [array_dim*data_w-1:0]   rd_data,
   input  logic                          fifo_has_space,
   output logic                          weight_en,
   output logic                          input_en,
   output logic                          partial_en,
   output logic [$clog2(array_dim)-1:0]  row_en,
   output logic [array_dim*data_w-1:0]   row_data
);

   localparam int unsigned row_w     = array_dim * data_w;
   localparam int unsigned row_idx_w = $clog2(array_dim);
   localparam int unsigned tag_w     = 2 + row_idx_w;

   loader_state_t state_q, state_d;

   logic [addr_w-1:0]    base_w_q, base_w_d;
   logic [addr_w-1:0]    base_i_q, base_i_d;
   logic [addr_w-1:0]    base_p_q, base_p_d;
   logic [15:0]          num_q, num_d;
   logic [row_idx_w-1:0] w_cnt_q, w_cnt_d;
   logic [15:0]          k_q, k_d;

   logic                 req;
   logic [addr_w-1:0]    req_addr;
   row_kind_t            req_kind;
   logic [row_idx_w-1:0] req_idx;

   logic                 captured;
   logic [row_w-1:0]     cap_data;
   logic [tag_w-1:0]     cap_tag;
   row_kind_t            cap_kind;
   logic [row_idx_w-1:0] cap_idx;

   loader_rd_port #(
      .addr_w (addr_w),
      .row_w  (row_w),
      .tag_w  (tag_w)
   ) u_rd_port (
      .CLK      (CLK),
      .nRST     (nRST),
      .req      (req),
      .addr     (req_addr),
      .tag      ({req_kind, req_idx}),
      .rd_req   (rd_req),
      .rd_addr  (rd_addr),
      .rd_valid (rd_valid),
      .rd_data  (rd_data),
      .captured (captured),
      .cap_data (cap_data),
      .cap_tag  (cap_tag)
   );

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q  <= StIdle;
         base_w_q <= '0;
         base_i_q <= '0;
         base_p_q <= '0;
         num_q    <= '0;
         w_cnt_q  <= '0;
         k_q      <= '0;
      end else begin
         state_q  <= state_d;
         base_w_q <= base_w_d;
         base_i_q <= base_i_d;
         base_p_q <= base_p_d;
         num_q    <= num_d;
         w_cnt_q  <= w_cnt_d;
         k_q      <= k_d;
      end
   end

   // Each read state advances on the capture pulse of its own read, so the row strobe and
   // the state change land in the same cycle.
   always_comb begin
      state_d  = state_q;
      base_w_d = base_w_q;
      base_i_d = base_i_q;
      base_p_d = base_p_q;
      num_d    = num_q;
      w_cnt_d  = w_cnt_q;
      k_d      = k_q;
      req      = 1'b0;
      req_addr = '0;
      req_kind = RowWeight;
      req_idx  = w_cnt_q;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               base_w_d = base_w_addr;
               base_i_d = base_i_addr;
               base_p_d = base_p_addr;
               num_d    = num_inputs;
               w_cnt_d  = '0;
               k_d      = '0;
               state_d  = StWRd;
            end
         end

         StWRd: begin
            req      = 1'b1;
            req_addr = base_w_q + addr_w'(w_cnt_q);
            if (captured) begin
               w_cnt_d = w_cnt_q + 1'b1;
               if (w_cnt_q == row_idx_w'(array_dim - 1)) begin
                  state_d = (num_q == 16'd0) ? StDone : StIWait;
               end
            end
         end

         // The input read goes out in the very cycle space appears; StIRd then holds the
         // request through any memory wait states regardless of later space changes.
         StIWait: begin
            req      = fifo_has_space;
            req_addr = base_i_q + addr_w'(k_q);
            req_kind = RowInput;
            req_idx  = k_q[row_idx_w-1:0];
            if (fifo_has_space) begin
               state_d = StIRd;
            end
         end

         StIRd: begin
            req      = 1'b1;
            req_addr = base_i_q + addr_w'(k_q);
            req_kind = RowInput;
            req_idx  = k_q[row_idx_w-1:0];
            if (captured) begin
               state_d = StPRd;
            end
         end

         StPRd: begin
            req      = 1'b1;
            req_addr = base_p_q + addr_w'(k_q);
            req_kind = RowPartial;
            req_idx  = k_q[row_idx_w-1:0];
            if (captured) begin
               k_d     = k_q + 16'd1;
               state_d = ((k_q + 16'd1) == num_q) ? StDone : StIWait;
            end
         end

         StDone: begin
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign cap_kind = row_kind_t'(cap_tag[tag_w-1 -: 2]);
   assign cap_idx  = cap_tag[row_idx_w-1:0];

   assign weight_en  = captured && (cap_kind == RowWeight);
   assign input_en   = captured && (cap_kind == RowInput);
   assign partial_en = captured && (cap_kind == RowPartial);
   assign row_en     = cap_idx;
   assign row_data   = cap_data;

   assign busy = (state_q != StIdle);
   assign done = (state_q == StDone);

endmodule

// File: tb/tb_systolic_array_loader.sv
// Scoreboard bench for systolic_array_loader: commands push the expected row stream
// (computed directly from the command parameters) into a queue; a negedge monitor pops
// and compares each strobe/done the DUT presents.
module tb_systolic_array_loader;
   import systolic_pkg::*;

   localparam int AW = ADDR_W;
   localparam int RW = ROW_W;
   localparam int IW = ROW_IDX_W;
   localparam int K_W = 0, K_I = 1, K_P = 2, K_DONE = 3;

   logic          CLK;
   logic          nRST;
   logic          start;
   logic [AW-1:0] base_w_addr, base_i_addr, base_p_addr;
   logic [15:0]   num_inputs;
   logic          busy, done, rd_req, rd_valid, fifo_has_space;
   logic [AW-1:0] rd_addr;
   logic [RW-1:0] rd_data;
   logic          weight_en, input_en, partial_en;
   logic [IW-1:0] row_en;
   logic [RW-1:0] row_data;

   systolic_array_loader dut (
      .CLK            (CLK),
      .nRST           (nRST),
      .start          (start),
      .base_w_addr    (base_w_addr),
      .base_i_addr    (base_i_addr),
      .base_p_addr    (base_p_addr),
      .num_inputs     (num_inputs),
      .busy           (busy),
      .done           (done),
      .rd_req         (rd_req),
      .rd_addr        (rd_addr),
      .rd_valid       (rd_valid),
      .rd_data        (rd_data),
      .fifo_has_space (fifo_has_space),
      .weight_en      (weight_en),
      .input_en       (input_en),
      .partial_en     (partial_en),
      .row_en         (row_en),
      .row_data       (row_data)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input bit ok, input string name, input logic [79:0] act,
                        input logic [79:0] exp);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Scratchpad model: row content is a fixed function of its address.
   function automatic logic [RW-1:0] mem_row(input logic [AW-1:0] a);
      return {a ^ 16'h5A5A, ~a, a + 16'h1234, a};
   endfunction

   int          wait_n   = 0;
   int          wcnt     = 0;
   bit          noise_en = 0;
   logic        noise    = 1'b0;
   logic [RW-1:0] junk   = '0;
   bit          space_rand  = 0;
   logic        space_force = 1'b1;
   logic        rnd_space   = 1'b1;

   assign rd_valid       = rd_req ? (wcnt >= wait_n) : noise;
   assign rd_data        = rd_req ? mem_row(rd_addr) : junk;
   assign fifo_has_space = space_rand ? rnd_space : space_force;

   always @(posedge CLK) begin
      if (rd_req && !rd_valid) wcnt <= wcnt + 1;
      else wcnt <= 0;
      noise     <= noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
      junk      <= {$urandom, $urandom};
      rnd_space <= ($urandom_range(0, 3) != 0);
   end

   typedef struct packed {
      logic [1:0]    kind;
      logic [IW-1:0] idx;
      logic [RW-1:0] data;
   } ev_t;

   ev_t exp_q[$];

   // Reference model: the whole expected row stream for one command.
   task automatic push_model(input logic [AW-1:0] bw, input logic [AW-1:0] bi,
                             input logic [AW-1:0] bp, input int n);
      for (int r = 0; r < ARRAY_DIM; r++)
         exp_q.push_back({2'(K_W), IW'(r % ARRAY_DIM), mem_row(bw + AW'(r))});
      for (int k = 0; k < n; k++) begin
         exp_q.push_back({2'(K_I), IW'(k % ARRAY_DIM), mem_row(bi + AW'(k))});
         exp_q.push_back({2'(K_P), IW'(k % ARRAY_DIM), mem_row(bp + AW'(k))});
      end
      exp_q.push_back({2'(K_DONE), IW'(0), RW'(0)});
   endtask

   // Monitor
   bit          mon_en = 0;
   int          n_w_seen = 0, n_i_seen = 0, n_p_seen = 0;
   logic        prev_req = 1'b0, prev_valid = 1'b0;
   logic [AW-1:0] prev_addr = '0;
   int          n_en;
   logic [1:0]  got_kind;
   ev_t         e;

   always @(negedge CLK) begin
      if (mon_en) begin
         if (prev_req && !prev_valid)
            check(rd_req === 1'b1 && rd_addr === prev_addr, "rd_hold", {rd_req, rd_addr},
                  {1'b1, prev_addr});
         n_en = int'(weight_en) + int'(input_en) + int'(partial_en);
         if (n_en > 0 || done) begin
            check(n_en <= 1 && !(done && n_en > 0), "bus_excl",
                  {done, weight_en, input_en, partial_en}, 0);
            got_kind = weight_en ? 2'(K_W) : input_en ? 2'(K_I) : partial_en ? 2'(K_P)
                                                                 : 2'(K_DONE);
            if (got_kind == 2'(K_W)) n_w_seen++;
            if (got_kind == 2'(K_I)) n_i_seen++;
            if (got_kind == 2'(K_P)) n_p_seen++;
            if (exp_q.size() == 0) begin
               check(1'b0, "unexpected_event", got_kind, 0);
            end else begin
               e = exp_q.pop_front();
               check(got_kind == e.kind, "row_kind", got_kind, e.kind);
               if (got_kind == e.kind && e.kind != 2'(K_DONE)) begin
                  check(row_en == e.idx, "row_en", row_en, e.idx);
                  check(row_data == e.data, "row_data", row_data, e.data);
               end
               if (got_kind == 2'(K_DONE) && e.kind == 2'(K_DONE))
                  check(busy == 1'b1, "busy_during_done", busy, 1);
            end
         end
      end
      prev_req   = rd_req;
      prev_valid = rd_valid;
      prev_addr  = rd_addr;
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic issue_cmd(input logic [AW-1:0] bw, input logic [AW-1:0] bi,
                            input logic [AW-1:0] bp, input int n);
      push_model(bw, bi, bp, n);
      base_w_addr = bw;
      base_i_addr = bi;
      base_p_addr = bp;
      num_inputs  = 16'(n);
      start       = 1'b1;
      tick();
      start       = 1'b0;
      base_w_addr = AW'($urandom);
      base_i_addr = AW'($urandom);
      base_p_addr = AW'($urandom);
      num_inputs  = 16'($urandom);
   endtask

   task automatic wait_idle(input int budget, input string name);
      int cyc = 0;
      while ((exp_q.size() != 0 || busy) && cyc < budget) begin
         tick();
         cyc++;
      end
      check(cyc < budget, name, cyc, budget);
      check(busy == 1'b0 && done == 1'b0, "idle_after_cmd", {busy, done}, 0);
   endtask

   task automatic check_all_zero(input string name);
      check({busy, done, rd_req, weight_en, input_en, partial_en} == 6'b0, name,
            {busy, done, rd_req, weight_en, input_en, partial_en}, 0);
      check(rd_addr == '0 && row_en == '0 && row_data == '0, name,
            {rd_addr, row_en}, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   int lat;
   bit seen;
   logic [AW-1:0] rbw, rbi, rbp;
   int rn;

   initial begin
      nRST = 1'b0; start = 1'b0;
      base_w_addr = '0; base_i_addr = '0; base_p_addr = '0; num_inputs = '0;
      repeat (3) tick();
      check_all_zero("reset_state");
      nRST = 1'b1;
      tick();
      mon_en = 1;

      // Weights only, zero-wait memory; first weight_en two cycles after start.
      issue_cmd(16'h0010, 16'h0000, 16'h0000, 0);
      lat = 1;
      while (!weight_en && lat < 10) begin
         tick();
         lat++;
      end
      check(lat == 2, "first_weight_latency", lat, 2);
      wait_idle(100, "timeout_weights_only");

      // Full command with index wrap.
      issue_cmd(16'h0000, 16'h0040, 16'h0080, 6);
      wait_idle(200, "timeout_full_cmd");

      // Backpressure: no input read while space is low; partial not stalled by space.
      space_force = 1'b0;
      n_w_seen = 0; n_p_seen = 0;
      issue_cmd(16'h0100, 16'h0200, 16'h0300, 2);
      lat = 0;
      while (n_w_seen < ARRAY_DIM && lat < 50) begin
         tick();
         lat++;
      end
      check(lat < 50, "timeout_bp_weights", lat, 50);
      for (int i = 0; i < 5; i++) begin
         check(rd_req == 1'b0, "bp_rd_req_low", rd_req, 0);
         tick();
      end
      space_force = 1'b1;
      #1;
      check(rd_req == 1'b1 && rd_addr == 16'h0200, "bp_read_on_space", {rd_req, rd_addr},
            {1'b1, 16'h0200});
      tick();
      space_force = 1'b0;
      repeat (4) tick();
      check(n_p_seen == 1, "bp_partial_not_stalled", n_p_seen, 1);
      space_force = 1'b1;
      wait_idle(100, "timeout_backpressure");

      // Memory wait states.
      wait_n = 3;
      issue_cmd(16'h0500, 16'h0600, 16'h0700, 3);
      wait_idle(300, "timeout_wait_states");
      wait_n = 0;

      // Start while busy is ignored.
      issue_cmd(16'h0020, 16'h0030, 16'h0050, 4);
      repeat (7) tick();
      base_w_addr = 16'h0AAA; base_i_addr = 16'h0BBB; base_p_addr = 16'h0CCC;
      num_inputs = 16'd9;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_idle(200, "timeout_start_busy");

      // Reset during the second input pair: outputs clear, no done afterwards.
      n_i_seen = 0;
      issue_cmd(16'h0900, 16'h0A00, 16'h0B00, 4);
      lat = 0;
      while (n_i_seen < 2 && lat < 100) begin
         tick();
         lat++;
      end
      check(lat < 100, "timeout_reset_wait", lat, 100);
      mon_en = 0;
      nRST = 1'b0;
      exp_q.delete();
      tick();
      check_all_zero("reset_mid_cmd");
      nRST = 1'b1;
      tick();
      mon_en = 1;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         if (done || busy) seen = 1;
         tick();
      end
      check(!seen, "no_done_after_reset", seen, 0);
      issue_cmd(16'h0C00, 16'h0D00, 16'h0E00, 2);
      wait_idle(100, "timeout_after_reset");

      // Randomised commands with address wrap, wait states, noise and space toggling.
      space_rand = 1;
      noise_en   = 1;
      for (int t = 0; t < 6; t++) begin
         rbw = AW'($urandom);
         rbi = AW'($urandom);
         rbp = AW'($urandom);
         if (t == 0) begin
            rbw = 16'hFFFE; rbi = 16'hFFFD; rbp = 16'hFFFF;
         end
         rn = $urandom_range(0, 7);
         wait_n = $urandom_range(0, 2);
         issue_cmd(rbw, rbi, rbp, rn);
         wait_idle(3000, "timeout_random_cmd");
      end
      space_rand = 0;
      noise_en   = 0;
      repeat (3) tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
